// File: rtl/rgb_arb_pkg.sv
// rgb_arb_pkg
// Shared types and constants for the RGB LED arbiter.
//   arb_state_e : arbiter FSM states (IDLE, HOLD, GAP)
//   RED..OFF    : 3-bit {R,G,B} colour codes
//   rr_index()  : round-robin candidate index helper
package rgb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] OFF     = 3'b000;

  // k-th candidate when scanning round-robin from the slot after 'last'.
  // last <= n-1 and k <= n-1, so a single wrap is always enough.
  function automatic int rr_index(input int last, input int k, input int n);
    int idx;
    idx = last + 1 + k;
    if (idx >= n) idx = idx - n;
    return idx;
  endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// rgb_tick_gen
// Free-running divider producing a one-cycle strobe every TICKS cycles.
// A synchronous clear restarts the period so the first strobe after a
// clear lands exactly TICKS cycles later.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear of the divider
//   tick : strobe, high on the last cycle of each period
module rgb_tick_gen
  import rgb_arb_pkg::*;
#(
  parameter int TICKS = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign tick = (cnt_q == TW'(TICKS - 1));

  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter
// Round-robin arbiter granting one RGB LED to N_REQ requesters. The winner
// holds the LED for max(dur_ms,1) milliseconds, then a 1 ms dark gap
// follows before the next arbitration.
// Optional feature macro: RGB_ARB_PWM_EN -- when defined, the colour is
// dimmed by a free-running 8-bit PWM with duty PWM_DUTY/256.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   req[N_REQ]       : level requests, held until done or abandoned
//   color[N_REQ][3]  : {R,G,B} per requester, sampled at grant
//   dur_ms[N_REQ][16]: hold time in ms per requester, sampled at grant
//   grant[N_REQ]     : one-hot owner, zero when no owner
//   done[N_REQ]      : one-cycle pulse on normal hold completion
//   RGB_R/G/B        : registered LED channel drives
//   LED              : busy indicator (HOLD or GAP)
module rgb_led_arbiter
  import rgb_arb_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int N_REQ    = 3,
  parameter int PWM_DUTY = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0][2:0]  color,
  input  logic [N_REQ-1:0][15:0] dur_ms,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   RGB_R,
  output logic                   RGB_G,
  output logic                   RGB_B,
  output logic                   LED
);

  localparam int TPM = CLK_FREQ / 1000;  // cycles per millisecond
  localparam int IW  = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TPM < 1 || PWM_DUTY < 0 || PWM_DUTY > 256) begin : g_bad_params
    $error("rgb_led_arbiter: unsupported parameter set");
  end

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;   // last owner, also current owner
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q,  done_d;
  logic [2:0]       col_q,   col_d;
  logic [15:0]      dur_q,   dur_d;
  logic [15:0]      ms_q,    ms_d;
  logic             tick;
  logic             tick_clr;

  logic [IW-1:0]    winner;
  logic [IW-1:0]    cand;
  logic             found;

  rgb_tick_gen #(
    .TICKS (TPM)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Scan from the slot after the last owner; first requester found wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'(rr_index(int'(owner_q), k, N_REQ));
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    done_d   = '0;
    col_d    = col_q;
    dur_d    = dur_q;
    ms_d     = ms_q;
    tick_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d         = HOLD;
          owner_d         = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          col_d           = color[winner];
          dur_d           = (dur_ms[winner] == 16'd0) ? 16'd1 : dur_ms[winner];
          ms_d            = '0;
          tick_clr        = 1'b1;
        end
      end
      HOLD: begin
        // An abandoned request takes priority over a same-cycle completion,
        // so an owner that lets go never sees done.
        if (!req[owner_q]) begin
          state_d  = GAP;
          grant_d  = '0;
          col_d    = OFF;
          tick_clr = 1'b1;
        end else if (tick) begin
          if (ms_q == dur_q - 16'd1) begin
            state_d         = GAP;
            done_d[owner_q] = 1'b1;
            grant_d         = '0;
            col_d           = OFF;
            tick_clr        = 1'b1;
          end else begin
            ms_d = ms_q + 16'd1;
          end
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= IW'(N_REQ - 1);  // so index 0 wins first
      grant_q <= '0;
      done_q  <= '0;
      col_q   <= OFF;
      dur_q   <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      col_q   <= col_d;
      dur_q   <= dur_d;
      ms_q    <= ms_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign LED   = (state_q != IDLE);

`ifdef RGB_ARB_PWM_EN
  // Gate with the counter value the output register will be paired with,
  // so RGB == col_q & (pwm_cnt_q < PWM_DUTY) holds on every cycle.
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic [2:0] rgb_q,     rgb_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    rgb_d     = col_d & {3{int'(pwm_cnt_d) < PWM_DUTY}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      rgb_q     <= OFF;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      rgb_q     <= rgb_d;
    end
  end

  assign {RGB_R, RGB_G, RGB_B} = rgb_q;
`else
  assign {RGB_R, RGB_G, RGB_B} = col_q;
`endif

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter
// Directed bench for rgb_led_arbiter at CLK_FREQ=12000 (12 cycles/ms),
// N_REQ=3. Inputs driven 1 time unit after posedge, outputs sampled there.
module tb_rgb_led_arbiter;
  import rgb_arb_pkg::*;

  localparam int CLK_FREQ = 12000;
  localparam int N_REQ    = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ-1:0][2:0]  color = '0;
  logic [N_REQ-1:0][15:0] dur_ms = '0;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   RGB_R, RGB_G, RGB_B, LED;
  logic [2:0]             rgb;

  int n_cmp = 0;
  int n_mis = 0;

  assign rgb = {RGB_R, RGB_G, RGB_B};

  always #5 clk = ~clk;

  rgb_led_arbiter #(
    .CLK_FREQ (CLK_FREQ),
    .N_REQ    (N_REQ),
    .PWM_DUTY (64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .color  (color),
    .dur_ms (dur_ms),
    .grant  (grant),
    .done   (done),
    .RGB_R  (RGB_R),
    .RGB_G  (RGB_G),
    .RGB_B  (RGB_B),
    .LED    (LED)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rgb_ok(input logic [2:0] got, input logic [2:0] col);
`ifdef RGB_ARB_PWM_EN
    return (got === col) || (got === 3'b000);
`else
    return got === col;
`endif
  endfunction

  // Count consecutive cycles owned by g; flag any cycle with wrong RGB/LED.
  task automatic measure_hold(input logic [2:0] g, input logic [2:0] col,
                              output int len, output bit bad);
    len = 0;
    bad = 1'b0;
    while (grant === g && len < 2000) begin
      if (!rgb_ok(rgb, col) || LED !== 1'b1) bad = 1'b1;
      len++;
      step();
    end
  endtask

  // Count GAP cycles (busy, no owner) and the cycles carrying a done pulse.
  task automatic gap_len(output int len, output int done_cycles);
    len = 0;
    done_cycles = 0;
    while (LED === 1'b1 && grant === '0 && len < 200) begin
      if (done !== '0) done_cycles++;
      if (rgb !== 3'b000) done_cycles += 100;
      len++;
      step();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (LED !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(LED), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int dc;
    int n;
    int hi;
    bit bad;
    logic [2:0] expg [4];
    logic [2:0] expc [4];
    expg = '{3'b001, 3'b010, 3'b100, 3'b001};
    expc = '{RED, GREEN, BLUE, RED};

    // ---------------- reset state
    rst = 1'b1;
    step();
    step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_rgb",   32'(rgb),   32'd0);
    check("rst_led",   32'(LED),   32'd0);
    rst = 1'b0;
    step();
    check("idle_no_req_grant", 32'(grant), 32'd0);
    $display("[tb] reset: grant=%b done=%b rgb=%b led=%b", grant, done, rgb, LED);

    // ---------------- single request, YELLOW, 2 ms
    color[1] = YELLOW;
    dur_ms[1] = 16'd2;
    req = 3'b010;
    step();
    check("single_grant", 32'(grant), 32'b010);
    check("single_rgb_first", 32'(rgb_ok(rgb, YELLOW)), 32'd1);
    measure_hold(3'b010, YELLOW, len, bad);
    check("single_hold_len", 32'(len), 32'd24);
    check("single_hold_rgb_led", 32'(bad), 32'd0);
    check("single_done", 32'(done), 32'b010);
    check("single_rgb_off", 32'(rgb), 32'd0);
    req = 3'b000;
    gap_len(len, dc);
    check("single_gap_len", 32'(len), 32'd12);
    check("single_done_cycles", 32'(dc), 32'd1);
    check("single_idle", 32'(LED), 32'd0);
    $display("[tb] single: owner=1 hold=24 gap=%0d", len);

    // ---------------- contention from reset
    color[0] = RED;
    color[1] = GREEN;
    color[2] = BLUE;
    dur_ms = '0;
    dur_ms[0] = 16'd1;
    dur_ms[1] = 16'd1;
    dur_ms[2] = 16'd1;
    rst = 1'b1;
    req = 3'b111;
    step();
    step();
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (grant === '0 && n < 50) begin
        step();
        n++;
      end
      check($sformatf("rr_grant%0d", g), 32'(grant), 32'(expg[g]));
      measure_hold(expg[g], expc[g], len, bad);
      check($sformatf("rr_hold%0d", g), 32'(len), 32'd12);
      check($sformatf("rr_done%0d", g), 32'(done), 32'(expg[g]));
      gap_len(len, dc);
      check($sformatf("rr_gap%0d", g), 32'(len), 32'd12);
      $display("[tb] contention: grant #%0d to %b gap=%0d", g, expg[g], len);
    end
    req = 3'b000;
    step();
    check("rr_quiet", 32'(grant), 32'd0);

    // ---------------- abort: req[2] dropped 5 cycles into a 3 ms hold
    color[2] = BLUE;
    dur_ms[2] = 16'd3;
    req = 3'b100;
    step();
    check("abort_grant", 32'(grant), 32'b100);
    repeat (4) step();
    check("abort_held_c5", 32'(grant), 32'b100);
    req = 3'b000;
    step();
    check("abort_grant_off", 32'(grant), 32'd0);
    check("abort_rgb_off",   32'(rgb),   32'd0);
    check("abort_no_done",   32'(done),  32'd0);
    check("abort_led",       32'(LED),   32'd1);
    gap_len(len, dc);
    check("abort_gap_len", 32'(len), 32'd12);
    check("abort_done_cycles", 32'(dc), 32'd0);
    $display("[tb] abort: owner=2 dropped at hold cycle 5 gap=%0d", len);

    // ---------------- zero duration treated as 1 ms
    color[0] = GREEN;
    dur_ms[0] = 16'd0;
    req = 3'b001;
    step();
    check("zero_grant", 32'(grant), 32'b001);
    measure_hold(3'b001, GREEN, len, bad);
    check("zero_hold_len", 32'(len), 32'd12);
    check("zero_done", 32'(done), 32'b001);
    req = 3'b000;
    wait_idle("zero_idle");
    $display("[tb] zero_dur: owner=0 hold=%0d", len);

    // ---------------- reset on hold cycle 7
    color[1] = CYAN;
    dur_ms[1] = 16'd3;
    req = 3'b010;
    step();
    check("rmh_grant", 32'(grant), 32'b010);
    repeat (6) step();
    rst = 1'b1;
    step();
    check("rmh_grant_off", 32'(grant), 32'd0);
    check("rmh_done_off",  32'(done),  32'd0);
    check("rmh_rgb_off",   32'(rgb),   32'd0);
    check("rmh_led_off",   32'(LED),   32'd0);
    rst = 1'b0;
    req = 3'b011;
    step();
    check("rmh_next_grant", 32'(grant), 32'b001);
    req = 3'b000;
    wait_idle("rmh_idle");
    $display("[tb] reset_mid_hold: next grant to index 0");

    // ---------------- brightness of a RED hold over 256 cycles
    color[0] = RED;
    dur_ms[0] = 16'd25;
    req = 3'b001;
    step();
    check("duty_grant", 32'(grant), 32'b001);
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      if (RGB_R === 1'b1) hi++;
      step();
    end
`ifdef RGB_ARB_PWM_EN
    check("duty_red_high", 32'(hi), 32'd64);
`else
    check("duty_red_high", 32'(hi), 32'd256);
`endif
    check("duty_still_held", 32'(grant), 32'b001);
    req = 3'b000;
    wait_idle("duty_idle");
    $display("[tb] duty: RGB_R high %0d of 256 cycles", hi);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
RGB_LED_ARBITER -- requirements
Module: rgb_led_arbiter

Interface
REQ-001 Parameter CLK_FREQ, default 12000000, meaning clk frequency in Hz.
REQ-002 Parameter N_REQ, default 3, meaning number of requesters (2..8).
REQ-003 Parameter PWM_DUTY, default 64, meaning 8-bit brightness duty in 1/256 units (used only with RGB_ARB_PWM_EN).
REQ-004 Ports: clk  in  1  single system clock; all logic on posedge clk.
REQ-005 Ports: rst  in  1  reset, synchronous and active-high.
REQ-006 Ports: req  in  N_REQ  per-requester level request; held until done or abandoned.
REQ-007 Ports: color  in  N_REQ x 3  per-requester {R,G,B} colour, sampled at grant only.
REQ-008 Ports: dur_ms  in  N_REQ x 16  per-requester hold time in ms, sampled at grant only.
REQ-009 Ports: grant  out  N_REQ  one-hot owner indication, all zero when no owner.
REQ-010 Ports: done  out  N_REQ  one-cycle pulse to owner at normal hold completion.
REQ-011 Ports: RGB_R, RGB_G, RGB_B  out  1 each  active-high LED channel drives, registered.
REQ-012 Ports: LED  out  1  busy indicator, high in HOLD and GAP.

Function
REQ-013 Block SHALL implement states IDLE, HOLD, GAP.
REQ-014 IDLE: when any req bit is high, block SHALL select winner by round-robin starting at index (last_owner+1) mod N_REQ, enter HOLD next cycle, assert grant[winner], latch color and dur_ms.
REQ-015 HOLD: RGB outputs SHALL equal latched colour from the first HOLD cycle, coincident with grant.
REQ-016 HOLD SHALL last exactly max(dur_ms,1) x (CLK_FREQ/1000) cycles; dur_ms=0 SHALL be treated as 1.
REQ-017 Integer division CLK_FREQ/1000 SHALL truncate; hold counter SHALL be 16 bits, tick divider $clog2(CLK_FREQ/1000) bits, no overflow at dur_ms=65535.
REQ-018 At hold completion block SHALL pulse done[owner] for one cycle, drop grant and RGB outputs the same cycle, enter GAP.
REQ-019 If req[owner] falls during HOLD, block SHALL abort next cycle: grant and RGB low, no done pulse, enter GAP.
REQ-020 GAP SHALL last exactly CLK_FREQ/1000 cycles with RGB outputs low, then return to IDLE.
REQ-021 last_owner SHALL update on every grant; requests arriving in HOLD/GAP SHALL wait; no requester starves beyond N_REQ-1 intervening grants.
REQ-022 Tick divider SHALL be cleared on entry to HOLD and GAP so timing is grant-aligned.

Reset
REQ-023 With rst high at a clk edge: state IDLE, grant=0, done=0, RGB_R/G/B=0, LED=0, last_owner=N_REQ-1 (index 0 wins first), counters 0.
REQ-024 Reset asserted mid-HOLD SHALL abandon the owner without a done pulse.

Configuration
REQ-025 Macro RGB_ARB_PWM_EN defined: each RGB output SHALL be latched colour AND (pwm_cnt < PWM_DUTY), with free-running 8-bit pwm_cnt reset to 0.
REQ-026 Macro RGB_ARB_PWM_EN undefined: RGB outputs SHALL be latched colour at full on; no PWM counter; PWM_DUTY ignored.

Structure
REQ-027 Package rgb_arb_pkg SHALL hold the state enum (IDLE, HOLD, GAP) and 3-bit colour constants RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA, OFF.
REQ-028 Sub-module rgb_tick_gen SHALL produce the 1 ms strobe with synchronous clear input; arbiter instantiates it once.

Verification (CLK_FREQ=12000 -> 12 cycles/ms, N_REQ=3)
REQ-029 Single: req[1]=1, color=YELLOW(3'b110), dur_ms=2 -> grant[1] and RGB=110 one cycle later for 24 cycles, done[1] pulse, 12-cycle GAP, LED high throughout.
REQ-030 Contention: req=3'b111 from reset -> grants in order 0,1,2,0 each separated by 12-cycle GAP.
REQ-031 Abort: req[2] dropped 5 cycles into a 3 ms hold -> grant/RGB low next cycle, no done[2], GAP entered.
REQ-032 Zero duration: dur_ms=0 -> hold of exactly 12 cycles then done pulse.
REQ-033 Reset mid-HOLD: rst pulsed on cycle 7 of hold -> all outputs 0 next edge, next req=3'b011 grants index 0.
REQ-034 PWM build, PWM_DUTY=64: RGB_R high 64 of every 256 cycles during a RED hold; non-PWM build: RGB_R constant high.
